// File: rtl/twiddle_pkg.sv
// Shared types and elaboration-time twiddle math for the FFT twiddle sequencer.
package twiddle_pkg;

  localparam real Pi = 3.14159265358979323846;
  localparam int unsigned DefNbits = 9;

  typedef enum logic {StIdle = 1'b0, StRun = 1'b1} state_e;

  typedef struct packed {
    logic signed [DefNbits-1:0] re;
    logic signed [DefNbits-1:0] im;
  } tw_t;

  function automatic int scale_f(int nbits);
    return 1 << (nbits - 2);
  endfunction

  function automatic int log2n_f(int n);
    return $clog2(n);
  endfunction

  // Round half away from zero.
  function automatic int round_away_f(real v);
    if (v >= 0.0) return $rtoi(v + 0.5);
    else return -$rtoi(-v + 0.5);
  endfunction

  function automatic int tw_re_f(int k, int n, int nbits);
    real ang;
    ang = 2.0 * Pi * real'(k) / real'(n);
    return round_away_f(real'(scale_f(nbits)) * $cos(ang));
  endfunction

  function automatic int tw_im_f(int k, int n, int nbits);
    real ang;
    ang = 2.0 * Pi * real'(k) / real'(n);
    return round_away_f(-real'(scale_f(nbits)) * $sin(ang));
  endfunction

endpackage

// File: rtl/twiddle_rom.sv
// Combinational N/2-entry twiddle lookup, contents fixed at elaboration.
module twiddle_rom import twiddle_pkg::*; #(
  parameter int unsigned NBITS = 9,
  parameter int unsigned N     = 8,
  localparam int unsigned KW   = $clog2(N) - 1
) (
  input  logic        [KW-1:0]    k_i,
  output logic signed [NBITS-1:0] re_o,
  output logic signed [NBITS-1:0] im_o
);

  logic signed [NBITS-1:0] re_tab [N/2];
  logic signed [NBITS-1:0] im_tab [N/2];

  for (genvar i = 0; i < int'(N / 2); i++) begin : g_tab
    assign re_tab[i] = NBITS'(tw_re_f(i, int'(N), int'(NBITS)));
    assign im_tab[i] = NBITS'(tw_im_f(i, int'(N), int'(NBITS)));
  end

  assign re_o = re_tab[k_i];
  assign im_o = im_tab[k_i];

endmodule

// File: rtl/twiddle_seq.sv
// Streams radix-2 DIT twiddle factors stage by stage over a valid/ready link.
// Optional IFFT conjugation is enabled by defining IFFT_CONJ_EN (adds the inv port).
module twiddle_seq import twiddle_pkg::*; #(
  parameter int unsigned NBITS  = 9,
  parameter int unsigned N      = 8,
  localparam int unsigned LOG2N = log2n_f(N),
  localparam int unsigned SW    = $clog2(LOG2N),
  localparam int unsigned KW    = LOG2N - 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
`ifdef IFFT_CONJ_EN
  input  logic                    inv,
`endif
  output logic                    busy,
  output logic                    tw_valid,
  input  logic                    tw_ready,
  output logic signed [NBITS-1:0] tw_re,
  output logic signed [NBITS-1:0] tw_im,
  output logic        [SW-1:0]    tw_stage,
  output logic        [KW-1:0]    tw_k,
  output logic                    tw_last
);

  localparam int unsigned BMax = N / 2 - 1;

  state_e                  state_q, state_d;
  logic [SW-1:0]           s_q, s_d;
  logic [KW-1:0]           b_q, b_d, k_q, k_d, k_mask;
  logic signed [NBITS-1:0] re_q, re_d, im_q, im_d, rom_re, rom_im;
  logic                    last_q, last_d, inv_d;
  logic                    accept, frame_go, advance, load;

  assign accept   = (state_q == StRun) & tw_ready;
  assign frame_go = (state_q == StIdle) & start;
  assign advance  = accept & ~last_q;
  assign load     = frame_go | advance;

`ifdef IFFT_CONJ_EN
  logic inv_q;
  assign inv_d = frame_go ? inv : inv_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) inv_q <= 1'b0;
    else     inv_q <= inv_d;
  end
`else
  assign inv_d = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (start) state_d = StRun;
      StRun:   if (accept && last_q) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    busy     = (state_q == StRun);
    tw_valid = (state_q == StRun);
    tw_re    = re_q;
    tw_im    = im_q;
    tw_stage = s_q;
    tw_k     = k_q;
    tw_last  = last_q;
  end

  // s/b walk the frame; k = (b mod 2**s) << (LOG2N-1-s).
  always_comb begin
    s_d = s_q;
    b_d = b_q;
    if (frame_go) begin
      s_d = '0;
      b_d = '0;
    end else if (advance) begin
      if (b_q == KW'(BMax)) begin
        b_d = '0;
        s_d = s_q + 1'b1;
      end else begin
        b_d = b_q + 1'b1;
      end
    end
    k_mask = ~({KW{1'b1}} << s_d);
    k_d    = (b_d & k_mask) << (SW'(KW) - s_d);
  end

  twiddle_rom #(
    .NBITS (NBITS),
    .N     (N)
  ) u_rom (
    .k_i  (k_d),
    .re_o (rom_re),
    .im_o (rom_im)
  );

  always_comb begin
    re_d   = re_q;
    im_d   = im_q;
    last_d = last_q;
    if (load) begin
      re_d   = rom_re;
      im_d   = inv_d ? -rom_im : rom_im;
      last_d = (s_d == SW'(LOG2N - 1)) && (b_d == KW'(BMax));
    end else if (accept && last_q) begin
      last_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_q    <= '0;
      b_q    <= '0;
      k_q    <= '0;
      re_q   <= '0;
      im_q   <= '0;
      last_q <= 1'b0;
    end else begin
      s_q    <= s_d;
      b_q    <= b_d;
      if (load) k_q <= k_d;
      re_q   <= re_d;
      im_q   <= im_d;
      last_q <= last_d;
    end
  end

endmodule

// File: tb/tb_twiddle_seq.sv
// Self-checking bench for twiddle_seq (N=8, NBITS=9); frame model derived from the index rules.
module tb_twiddle_seq;
  import twiddle_pkg::*;

  localparam int NB    = 9;
  localparam int NP    = 8;
  localparam int HALF  = NP / 2;
  localparam int FRAME = 12;

  logic clk = 1'b0;
  logic rst, start, tw_ready;
  logic busy, tw_valid, tw_last;
  logic signed [NB-1:0] tw_re, tw_im;
  logic [1:0] tw_stage, tw_k;
`ifdef IFFT_CONJ_EN
  logic inv;
`endif

  always #5 clk = ~clk;

  twiddle_seq #(.NBITS(NB), .N(NP)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
`ifdef IFFT_CONJ_EN
    .inv      (inv),
`endif
    .busy     (busy),
    .tw_valid (tw_valid),
    .tw_ready (tw_ready),
    .tw_re    (tw_re),
    .tw_im    (tw_im),
    .tw_stage (tw_stage),
    .tw_k     (tw_k),
    .tw_last  (tw_last)
  );

  int total = 0;
  int bad = 0;
  int frames_done = 0;
  bit mdl_inv = 1'b0;
  int m_re [HALF];
  int m_im [HALF];
  int got_re [FRAME];
  int got_im [FRAME];
  int got_k  [FRAME];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int rnd(input real v);
    if (v >= 0.0) return int'($floor(v + 0.5));
    return -int'($floor(-v + 0.5));
  endfunction

  // Word idx of a frame: stage idx/HALF, butterfly idx%HALF.
  function automatic int exp_k(input int idx);
    int s, b;
    s = idx / HALF;
    b = idx % HALF;
    return (b % (1 << s)) * (NP >> (s + 1));
  endfunction

  initial begin : compare
    int idx, ek, pre, pim, pk, ps, pl;
    bit pv, stall, lastacc;
    idx = 0; pv = 0; stall = 0; lastacc = 0;
    pre = 0; pim = 0; pk = 0; ps = 0; pl = 0;
    forever begin
      @(negedge clk);
      if (rst === 1'b1) begin
        idx = 0; pv = 0; stall = 0; lastacc = 0;
      end else begin
        if (lastacc) begin
          chk("busy_after_last", busy, 0);
          chk("valid_after_last", tw_valid, 0);
          lastacc = 0;
        end else if (pv && !tw_valid) begin
          chk("frame_ended_early", idx, FRAME);
        end
        if (tw_valid && !pv) begin
          if (idx != 0) chk("prev_frame_len", idx, FRAME);
          idx = 0;
        end
        if (tw_valid) begin
          if (idx >= FRAME) begin
            chk("extra_word", idx, FRAME - 1);
          end else begin
            ek = exp_k(idx);
            chk("stage", tw_stage, idx / HALF);
            chk("k", tw_k, ek);
            chk("re", tw_re, m_re[ek]);
            chk("im", tw_im, mdl_inv ? -m_im[ek] : m_im[ek]);
            chk("last", tw_last, int'(idx == FRAME - 1));
            chk("busy", busy, 1);
          end
          if (stall) begin
            chk("hold_re", tw_re, pre);
            chk("hold_im", tw_im, pim);
            chk("hold_k", tw_k, pk);
            chk("hold_stage", tw_stage, ps);
            chk("hold_last", tw_last, pl);
          end
          if (tw_ready) begin
            if (idx < FRAME) begin
              got_re[idx] = tw_re;
              got_im[idx] = tw_im;
              got_k[idx]  = tw_k;
            end
            if (tw_last) begin
              lastacc = 1;
              frames_done++;
            end
            idx++;
            stall = 0;
          end else begin
            stall = 1;
            pre = tw_re; pim = tw_im; pk = tw_k; ps = tw_stage; pl = tw_last;
          end
        end else begin
          if (stall) chk("hold_valid", tw_valid, 1);
          stall = 0;
          chk("idle_busy", busy, 0);
        end
        pv = tw_valid;
      end
    end
  end

  task automatic pulse_start(input bit iv);
    @(negedge clk);
    start = 1'b1;
`ifdef IFFT_CONJ_EN
    inv = iv;
`endif
    @(posedge clk);
    #1;
    start = 1'b0;
`ifdef IFFT_CONJ_EN
    inv = ~iv;
`else
    if (iv) $display("note: inv requested without IFFT_CONJ_EN");
`endif
  endtask

  task automatic wait_done(input int f0, input int budget);
    for (int n = 0; n < budget; n++) begin
      @(negedge clk);
      if (frames_done > f0) break;
    end
    chk("frame_complete", frames_done, f0 + 1);
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_handshakes(input int cnt, input int budget);
    int n = 0;
    for (int c = 0; c < budget && n < cnt; c++) begin
      @(negedge clk);
      if (tw_valid && tw_ready) n++;
    end
    chk("handshakes_seen", n, cnt);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_valid"}, tw_valid, 0);
    chk({tag, "_re"}, tw_re, 0);
    chk({tag, "_im"}, tw_im, 0);
    chk({tag, "_stage"}, tw_stage, 0);
    chk({tag, "_k"}, tw_k, 0);
    chk({tag, "_last"}, tw_last, 0);
  endtask

  initial begin : main
    int f0;
    int kseq [FRAME];
    tw_t hand [HALF];
    kseq = '{0, 0, 0, 0, 0, 2, 0, 2, 0, 1, 2, 3};
    hand[0] = '{re: 9'sd128, im: 9'sd0};
    hand[1] = '{re: 9'sd91,  im: -9'sd91};
    hand[2] = '{re: 9'sd0,   im: -9'sd128};
    hand[3] = '{re: -9'sd91, im: -9'sd91};

    rst = 1'b0; start = 1'b0; tw_ready = 1'b1;
`ifdef IFFT_CONJ_EN
    inv = 1'b0;
`endif
    for (int k = 0; k < HALF; k++) begin
      m_re[k] = rnd(128.0 * $cos(2.0 * 3.14159265358979 * k / NP));
      m_im[k] = rnd(-128.0 * $sin(2.0 * 3.14159265358979 * k / NP));
    end
    // Pin the model itself against hand-worked values.
    for (int i = 0; i < FRAME; i++) chk("model_kseq", exp_k(i), kseq[i]);
    for (int k = 0; k < HALF; k++) begin
      chk("model_re", m_re[k], int'(hand[k].re));
      chk("model_im", m_im[k], int'(hand[k].im));
    end

    #2 rst = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Test 1/2: plain frame, ready held high.
    f0 = frames_done;
    @(negedge clk);
    chk("valid_before_start", tw_valid, 0);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    chk("first_valid", tw_valid, 1);
    chk("first_busy", busy, 1);
    wait_done(f0, 100);
    for (int i = 0; i < FRAME; i++) chk("dut_kseq", got_k[i], kseq[i]);
    chk("w1_re", got_re[0], 128);
    chk("w1_im", got_im[0], 0);
    chk("w10_re", got_re[9], 91);
    chk("w10_im", got_im[9], -91);
    chk("w11_im", got_im[10], -128);
    chk("w12_re", got_re[11], -91);

    // Test 4: start during the frame and on the final handshake.
    f0 = frames_done;
    pulse_start(1'b0);
    wait_handshakes(5, 100);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (tw_valid && tw_last) break;
    end
    chk("saw_last", tw_last, 1);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(f0, 100);
    repeat (3) begin
      @(negedge clk);
      chk("no_restart", busy, 0);
    end
    f0 = frames_done;
    pulse_start(1'b0);
    wait_done(f0, 100);

    // Test 3: random backpressure.
    f0 = frames_done;
    pulse_start(1'b0);
    for (int c = 0; c < 400; c++) begin
      @(posedge clk);
      #1 tw_ready = 1'($urandom_range(0, 1));
      if (frames_done > f0) break;
    end
    chk("bp_frame_done", frames_done, f0 + 1);
    tw_ready = 1'b1;
    repeat (3) @(negedge clk);
    for (int i = 0; i < FRAME; i++) chk("bp_kseq", got_k[i], kseq[i]);

    // Test 5: asynchronous reset mid-frame.
    pulse_start(1'b0);
    wait_handshakes(6, 100);
    @(posedge clk);
    #2 rst = 1'b1;
    #1 check_reset_vals("async_rst");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    f0 = frames_done;
    pulse_start(1'b0);
    wait_done(f0, 100);
    chk("restart_k0", got_k[0], 0);
    chk("restart_re0", got_re[0], 128);

`ifdef IFFT_CONJ_EN
    // Test 6: conjugate frame then forward frame.
    mdl_inv = 1'b1;
    f0 = frames_done;
    pulse_start(1'b1);
    wait_done(f0, 100);
    chk("inv_w10_re", got_re[9], 91);
    chk("inv_w10_im", got_im[9], 91);
    chk("inv_w11_im", got_im[10], 128);
    mdl_inv = 1'b0;
    f0 = frames_done;
    pulse_start(1'b0);
    wait_done(f0, 100);
    chk("fwd_w10_im", got_im[9], -91);
    chk("fwd_w11_im", got_im[10], -128);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
